// File: rtl/spi_master_multi_if.sv
// spi_master_multi_if: command/pin bundle of the SPI master; master = SPI engine side, slave = command FSM and pin side
interface spi_master_multi_if #(
  parameter int MAX_BITS = 152,
  parameter int LEN_W = 8,
  parameter int NUM_SS = 4,
  parameter int SS_W = 2
);
  logic start;
  logic [MAX_BITS-1:0] tx_data;
  logic [LEN_W-1:0] bit_len;
  logic cpol;
  logic cpha;
  logic lsb_first;
  logic [SS_W-1:0] ss_index;
  logic hold_ss;
  logic release_ss;
  logic miso;
  logic sclk;
  logic mosi;
  logic [NUM_SS-1:0] ss_n;
  logic busy;
  logic done;
  logic [MAX_BITS-1:0] rx_data;
  modport master (
    input start, tx_data, bit_len, cpol, cpha, lsb_first, ss_index, hold_ss, release_ss, miso,
    output sclk, mosi, ss_n, busy, done, rx_data
  );
  modport slave (
    output start, tx_data, bit_len, cpol, cpha, lsb_first, ss_index, hold_ss, release_ss, miso,
    input sclk, mosi, ss_n, busy, done, rx_data
  );
endinterface

// File: rtl/spi_master_multi.sv
// spi_master_multi: full-duplex SPI master with per-frame length, CPOL/CPHA, bit order, one-hot select and select hold; ports clk, rst, bus (master modport)
module spi_master_multi #(
  parameter int MAX_BITS = 152,
  parameter int LEN_W = 8,
  parameter int CLK_DIV = 500,
  parameter int NUM_SS = 4,
  parameter int SS_W = 2
) (
  input logic clk,
  input logic rst,
  spi_master_multi_if.master bus
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_END = DIV_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BITS);
  typedef enum logic [2:0] {IDLE, SETUP, XFER, TAIL, HOLD, GAP} state_t;
  state_t state;
  logic [DIV_W-1:0] div;
  logic [LEN_W-1:0] bcnt, len_l, len_eff;
  logic [MAX_BITS-1:0] tsh, rsh, tx_al;
  logic [SS_W-1:0] ss_l;
  logic cpol_l, cpha_l, lsb_l, hold_l, accept, tick, lead, last, samp;
  function automatic logic head(input logic [MAX_BITS-1:0] v, input logic lsb);
    return lsb ? v[0] : v[MAX_BITS-1];
  endfunction
  function automatic logic [MAX_BITS-1:0] adv(input logic [MAX_BITS-1:0] v, input logic lsb);
    return lsb ? v >> 1 : v << 1;
  endfunction
  function automatic logic [NUM_SS-1:0] sel(input logic [SS_W-1:0] i);
    return ~(NUM_SS'(1) << i);
  endfunction
  assign len_eff = bus.bit_len > MAX_L ? MAX_L : bus.bit_len;
  assign tx_al = bus.lsb_first ? bus.tx_data : bus.tx_data << (MAX_L - len_eff);
  assign accept = bus.start && len_eff != '0 && (state == IDLE || (state == HOLD && !bus.release_ss));
  assign tick = div == DIV_END;
  assign lead = bus.sclk == cpol_l;
  assign last = !lead && bcnt == len_l - LEN_W'(1);
  assign samp = lead != cpha_l;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div <= '0;
      bcnt <= '0;
      len_l <= '0;
      tsh <= '0;
      rsh <= '0;
      ss_l <= '0;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      lsb_l <= 1'b0;
      hold_l <= 1'b0;
      bus.sclk <= 1'b0;
      bus.mosi <= 1'b1;
      bus.ss_n <= '1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.rx_data <= '0;
    end else begin
      bus.done <= 1'b0;
      div <= tick ? '0 : div + DIV_W'(1);
      if (accept) begin
        cpol_l <= bus.cpol;
        cpha_l <= bus.cpha;
        lsb_l <= bus.lsb_first;
        hold_l <= bus.hold_ss;
        ss_l <= bus.ss_index;
        len_l <= len_eff;
        rsh <= '0;
        bcnt <= '0;
        div <= '0;
        bus.busy <= 1'b1;
        bus.sclk <= bus.cpol;
        if (state == HOLD && (bus.ss_index != ss_l || bus.cpol != cpol_l)) begin
          state <= GAP;
          bus.ss_n <= '1;
          bus.mosi <= 1'b1;
          tsh <= tx_al;
        end else begin
          state <= SETUP;
          bus.ss_n <= sel(bus.ss_index);
          tsh <= bus.cpha ? tx_al : adv(tx_al, bus.lsb_first);
          if (!bus.cpha) bus.mosi <= head(tx_al, bus.lsb_first);
        end
      end else begin
        case (state)
          GAP: if (tick) begin
            state <= SETUP;
            bus.ss_n <= sel(ss_l);
            if (!cpha_l) begin
              bus.mosi <= head(tsh, lsb_l);
              tsh <= adv(tsh, lsb_l);
            end
          end
          SETUP: if (tick) state <= XFER;
          XFER: if (tick) begin
            bus.sclk <= ~bus.sclk;
            if (samp) rsh <= lsb_l ? {bus.miso, rsh[MAX_BITS-1:1]} : {rsh[MAX_BITS-2:0], bus.miso};
            else if (!last) begin
              bus.mosi <= head(tsh, lsb_l);
              tsh <= adv(tsh, lsb_l);
            end
            if (!lead) bcnt <= bcnt + LEN_W'(1);
            if (last) state <= TAIL;
          end
          TAIL: if (tick) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            bus.rx_data <= lsb_l ? rsh >> (MAX_L - len_l) : rsh;
            state <= hold_l ? HOLD : IDLE;
            if (!hold_l) begin
              bus.ss_n <= '1;
              bus.mosi <= 1'b1;
            end
          end
          HOLD: if (bus.release_ss) begin
            state <= IDLE;
            bus.ss_n <= '1;
            bus.mosi <= 1'b1;
          end
          IDLE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: self-checking bench for spi_master_multi with vector table, done-driven scoreboard and select-hold/reset sequences
module tb_spi_master_multi;
  localparam int MB = 152;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_master_multi_if #(.MAX_BITS(MB), .LEN_W(8), .NUM_SS(4), .SS_W(2)) bus ();
  spi_master_multi #(.MAX_BITS(MB), .LEN_W(8), .CLK_DIV(4), .NUM_SS(4), .SS_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct {
    logic cpol;
    logic cpha;
    logic lsb;
    logic [1:0] ss;
    int len;
    logic [MB-1:0] tx;
    logic [MB-1:0] exp_rx;
    logic [3:0] exp_ss;
    int exp_done;
    bit slave;
  } vec_t;
  vec_t vecs[6];
  logic [MB-1:0] sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit slave_en = 1'b0;
  logic miso_r = 1'b0;
  logic [11:0] sl = 12'hF0F;
  assign bus.miso = slave_en ? miso_r : bus.mosi;
  always @(posedge bus.sclk) if (slave_en) begin
    miso_r = sl[11];
    sl = sl << 1;
  end
  function automatic void check_i(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction
  function automatic void check_v(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  always @(negedge clk) if (!rst && bus.done) begin
    done_cnt++;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_done: got done=1 expected no pulse (rx_data %0h)", bus.rx_data);
    end else check_v("rx_data", bus.rx_data, sb.pop_front());
  end
  task automatic set_in(input logic cpol, input logic cpha, input logic lsb, input logic [1:0] ss,
                        input logic hold, input int len, input logic [MB-1:0] tx);
    bus.cpol = cpol;
    bus.cpha = cpha;
    bus.lsb_first = lsb;
    bus.ss_index = ss;
    bus.hold_ss = hold;
    bus.bit_len = 8'(len);
    bus.tx_data = tx;
  endtask
  task automatic fire(input bit push, input logic [MB-1:0] e);
    bus.start = 1'b1;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input int bound, input logic [3:0] exp_ss, output int cyc, output int bad);
    cyc = 1;
    bad = 0;
    while (!bus.done && cyc < bound) begin
      if (bus.ss_n != exp_ss) bad++;
      @(negedge clk);
      cyc++;
    end
    if (bus.ss_n != exp_ss) bad++;
    if (!bus.done) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles expected a done pulse", bound);
    end
  endtask
  task automatic run_frame(input vec_t v);
    int n, c, edges, ss_bad, mosi_bad, busy_cyc, k;
    logic [MB-1:0] msk, mseq;
    logic ps, pm, drv;
    n = v.len > MB ? MB : v.len;
    msk = '0;
    mseq = '0;
    edges = 0;
    ss_bad = 0;
    mosi_bad = 0;
    busy_cyc = 0;
    k = 0;
    for (int i = 0; i < n; i++) msk[i] = 1'b1;
    set_in(v.cpol, v.cpha, v.lsb, v.ss, 1'b0, v.len, v.tx);
    slave_en = v.slave;
    ps = bus.sclk;
    pm = bus.mosi;
    fire(1'b1, v.exp_rx);
    c = 1;
    while (!bus.done && c < 2000) begin
      if (bus.busy) busy_cyc++;
      if (bus.busy && bus.ss_n != v.exp_ss) ss_bad++;
      drv = bus.sclk != ps && ((bus.sclk == v.cpol) != v.cpha);
      if (c > 1 && bus.sclk != ps) begin
        edges++;
        if (!drv) begin
          if (v.lsb) mseq[k] = bus.mosi;
          else mseq = {mseq[MB-2:0], bus.mosi};
          k++;
        end
      end
      if (c > 1 && bus.mosi != pm && !drv) mosi_bad++;
      ps = bus.sclk;
      pm = bus.mosi;
      @(negedge clk);
      c++;
    end
    slave_en = 1'b0;
    check_i("done_cycle", c, v.exp_done);
    check_i("busy_cycles", busy_cyc, v.exp_done - 1);
    check_i("sclk_edges", edges, 2 * n);
    check_i("ss_n_bad_cycles", ss_bad, 0);
    check_i("mosi_off_edge_changes", mosi_bad, 0);
    check_v("mosi_bits", mseq, v.tx & msk);
  endtask
  initial begin
    logic [MB-1:0] r1, r2, r3;
    int cyc, bad, d0, cnt;
    for (int i = 0; i < MB; i++) begin
      r1[i] = 1'($urandom_range(0, 1));
      r2[i] = 1'($urandom_range(0, 1));
      r3[i] = 1'($urandom_range(0, 1));
    end
    r2[15:0] = 16'h1234;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 2'd2, 8, 152'hA5, 152'hA5, 4'b1011, 73, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 2'd0, 152, r1, r1, 4'b1110, 1225, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 2'd3, 1, 152'h1, 152'h1, 4'b0111, 17, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 2'd1, 16, r2, 152'h1234, 4'b1101, 137, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 2'd2, 200, r3, r3, 4'b1011, 1225, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 2'd1, 12, 152'h5C3, 152'hF0F, 4'b1101, 105, 1'b1};
    bus.start = 1'b0;
    bus.release_ss = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8, '0);
    repeat (3) @(negedge clk);
    check_i("reset_sclk", int'(bus.sclk), 0);
    check_i("reset_mosi", int'(bus.mosi), 1);
    check_i("reset_ss_n", int'(bus.ss_n), 15);
    check_i("reset_busy", int'(bus.busy), 0);
    check_i("reset_done", int'(bus.done), 0);
    check_v("reset_rx_data", bus.rx_data, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i]);
      repeat (3) @(negedge clk);
    end
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8, 152'h3C);
    fire(1'b1, 152'h3C);
    wait_done(2000, 4'b1110, cyc, bad);
    check_i("hold_a_done_cycle", cyc, 73);
    check_i("hold_a_ss_bad", bad, 0);
    repeat (3) @(negedge clk);
    check_i("hold_ss_n", int'(bus.ss_n), 14);
    check_i("hold_busy", int'(bus.busy), 0);
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8, 152'h5A);
    fire(1'b1, 152'h5A);
    wait_done(2000, 4'b1110, cyc, bad);
    check_i("hold_b_done_cycle", cyc, 73);
    check_i("hold_b_ss_bad", bad, 0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 8, 152'h96);
    fire(1'b1, 152'h96);
    cnt = 0;
    while (bus.ss_n == 4'b1111 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check_i("gap_cycles", cnt, 4);
    check_i("gap_new_ss_n", int'(bus.ss_n), 13);
    wait_done(2000, 4'b1101, cyc, bad);
    check_i("gap_rest_cycles", cyc, 73);
    check_i("gap_ss_bad", bad, 0);
    @(negedge clk);
    bus.release_ss = 1'b1;
    @(negedge clk);
    bus.release_ss = 1'b0;
    check_i("release_ss_n", int'(bus.ss_n), 15);
    set_in(1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4, 152'hA);
    fire(1'b1, 152'hA);
    wait_done(2000, 4'b1011, cyc, bad);
    check_i("hold_d_done_cycle", cyc, 41);
    @(negedge clk);
    d0 = done_cnt;
    bus.tx_data = 152'h7;
    bus.start = 1'b1;
    bus.release_ss = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.release_ss = 1'b0;
    check_i("start_release_ss_n", int'(bus.ss_n), 15);
    cnt = 0;
    repeat (20) begin
      if (bus.busy) cnt++;
      @(negedge clk);
    end
    check_i("start_release_busy", cnt, 0);
    check_i("start_release_done", done_cnt - d0, 0);
    d0 = done_cnt;
    set_in(1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 4, 152'h9);
    fire(1'b1, 152'h9);
    repeat (10) @(negedge clk);
    bus.tx_data = 152'h6;
    fire(1'b0, '0);
    wait_done(200, 4'b0111, cyc, bad);
    repeat (60) @(negedge clk);
    check_i("busy_start_single_done", done_cnt - d0, 1);
    d0 = done_cnt;
    set_in(1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 0, '1);
    fire(1'b0, '0);
    cnt = 0;
    repeat (40) begin
      if (bus.busy || bus.ss_n != 4'b1111) cnt++;
      @(negedge clk);
    end
    check_i("len0_activity", cnt, 0);
    check_i("len0_done", done_cnt - d0, 0);
    d0 = done_cnt;
    set_in(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 8, 152'hC3);
    fire(1'b0, '0);
    repeat (20) @(negedge clk);
    check_i("pre_reset_busy", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_i("midrst_sclk", int'(bus.sclk), 0);
    check_i("midrst_mosi", int'(bus.mosi), 1);
    check_i("midrst_ss_n", int'(bus.ss_n), 15);
    check_i("midrst_busy", int'(bus.busy), 0);
    check_i("midrst_done", int'(bus.done), 0);
    check_v("midrst_rx_data", bus.rx_data, '0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check_i("midrst_no_done", done_cnt - d0, 0);
    check_i("scoreboard_left", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
